gat_load_bridge: RTL

GAT_LOAD_BRIDGE -- requirements
Module: gat_load_bridge

---
 rtl/gat_load_pkg.sv | 19 +
 rtl/gat_load_bridge_if.sv | 34 +++
 rtl/gat_load_chan_cnt.sv | 38 +++
 rtl/gat_load_bridge.sv | 123 ++++++++++++
 4 files changed

// File: rtl/gat_load_pkg.sv
// Shared constants for the GAT BRAM load bridge: default parameters and FSM state codes.
package gat_load_pkg;

    localparam int DEF_TOP_WIDTH = 32;
    localparam int DEF_NUM_CH    = 3;
    localparam int DEF_DATA_W    = 20;
    localparam int DEF_DEPTH     = 242101;

    // Load sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Channel-select width; a single channel still gets one select bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gat_load_bridge_if.sv
// Host write port and BRAM write port of the load bridge, bundled as one interface.
interface gat_load_bridge_if
    import gat_load_pkg::*;
#(
    parameter int TOP_WIDTH = DEF_TOP_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = ch_width(NUM_CH);

    logic [CH_W-1:0]      host_ch;
    logic                 host_ena;
    logic                 host_wea;
    logic [ADDR_W+1:0]    host_addra;
    logic [TOP_WIDTH-1:0] host_din;

    logic [NUM_CH-1:0]    bram_ena;
    logic [NUM_CH-1:0]    bram_wea;
    logic [ADDR_W-1:0]    bram_addra;
    logic [DATA_W-1:0]    bram_din;

    modport master (
        output host_ch, host_ena, host_wea, host_addra, host_din,
        input  bram_ena, bram_wea, bram_addra, bram_din
    );

    modport slave (
        input  host_ch, host_ena, host_wea, host_addra, host_din,
        output bram_ena, bram_wea, bram_addra, bram_din
    );

endinterface

// File: rtl/gat_load_chan_cnt.sv
// Per-channel word counter: latches the expected count on clear, counts accepted
// writes and raises a sticky load_done once the count reaches the expectation.
module gat_load_chan_cnt #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             active,
    input  logic             inc,
    input  logic [CNT_W-1:0] exp_cnt,
    output logic             load_done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] exp_q;

    // Counter, expected-count latch and done flag (done trails the count by one cycle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            exp_q     <= '0;
            load_done <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            exp_q     <= exp_cnt;
            load_done <= 1'b0;
        end else begin
            if (inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (active && (cnt >= exp_q)) begin
                load_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gat_load_bridge.sv
// Routes host byte-addressed writes to one of NUM_CH BRAM load channels, checks
// alignment/range/overflow, and tracks per-channel completion of a load pass.
module gat_load_bridge
    import gat_load_pkg::*;
#(
    parameter int TOP_WIDTH = DEF_TOP_WIDTH,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic [NUM_CH*CNT_W-1:0] exp_cnt,
    gat_load_bridge_if.slave        bus,
    output logic [NUM_CH-1:0]       load_done,
    output logic                    all_done,
    output logic                    busy,
    output logic                    err_align,
    output logic                    err_range,
    output logic                    err_ovf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CH_W   = ch_width(NUM_CH);
    localparam int CH_N   = 1 << CH_W;
    localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic [1:0]        state;
    logic              in_load;
    logic              wr_req;
    logic              aligned;
    logic              ch_ok;
    logic              addr_ok;
    logic              ovf;
    logic              accept;
    logic [ADDR_W-1:0] word;
    logic [CH_N-1:0]   done_ext;
    logic [NUM_CH-1:0] inc;

    assign in_load  = (state == ST_LOAD);
    assign busy     = in_load;
    assign all_done = (state == ST_DONE);
    // Zero-extended so an out-of-range channel select never indexes past the vector
    assign done_ext = CH_N'(load_done);

    // Write qualification; load_start wins over a same-cycle write
    always_comb begin
        wr_req  = bus.host_ena && bus.host_wea && in_load && !load_start;
        aligned = (bus.host_addra[1:0] == 2'b00);
        word    = bus.host_addra[ADDR_W+1:2];
        ch_ok   = ({1'b0, bus.host_ch} < NUM_CH_V);
        addr_ok = ({1'b0, word} < DEPTH_V);
        ovf     = ch_ok && done_ext[bus.host_ch];
        accept  = wr_req && aligned && ch_ok && addr_ok && !ovf;
        inc     = '0;
        if (accept) begin
            inc = NUM_CH'(1) << bus.host_ch;
        end
    end

    // Load sequencer: any load_start (re)enters LOAD; all channels done moves to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (load_start) begin
            state <= ST_LOAD;
        end else if (in_load && (&load_done)) begin
            state <= ST_DONE;
        end
    end

    // Sticky error flags, cleared by a new load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_align <= 1'b0;
            err_range <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (load_start) begin
            err_align <= 1'b0;
            err_range <= 1'b0;
            err_ovf   <= 1'b0;
        end else if (wr_req) begin
            if (!aligned) err_align <= 1'b1;
            if (!ch_ok || !addr_ok) err_range <= 1'b1;
            if (ovf) err_ovf <= 1'b1;
        end
    end

    // BRAM port register: one-cycle strobe, address/data hold between writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bram_ena   <= '0;
            bus.bram_wea   <= '0;
            bus.bram_addra <= '0;
            bus.bram_din   <= '0;
        end else begin
            bus.bram_ena <= inc;
            bus.bram_wea <= inc;
            if (accept) begin
                bus.bram_addra <= word;
                bus.bram_din   <= bus.host_din[DATA_W-1:0];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gat_load_chan_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .clr      (load_start),
            .active   (in_load),
            .inc      (inc[c]),
            .exp_cnt  (exp_cnt[c*CNT_W +: CNT_W]),
            .load_done(load_done[c])
        );
    end

endmodule
